// File: rtl/pwconv_pkg.sv
// Shared constants for the pointwise-convolution engine: default datapath sizes and tag width.
package pwconv_pkg;
    localparam int PW_DW     = 8;
    localparam int PW_AW     = 32;
    localparam int PW_NLANE  = 32;
    localparam int PW_NPOINT = 4;
    localparam int PW_TAG_W  = 4;
endpackage

// File: rtl/pwconv_engine_point.sv
// One spatial point: NLANE-wide dot product (S1), accumulator (S2) and output register.
// Build option PWCONV_ENGINE_RELU_EN clamps the emitted value at zero.
module pwconv_engine_point import pwconv_pkg::*; #(
    parameter int NLANE = PW_NLANE,
    parameter int DW    = PW_DW,
    parameter int AW    = PW_AW
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                i_adv,
    input  logic                i_s1_valid,
    input  logic                i_s1_first,
    input  logic                i_s2_emit,
    input  logic [AW-1:0]       i_s1_bias,
    input  logic [NLANE*DW-1:0] i_weight,
    input  logic [NLANE*DW-1:0] i_data,
    output logic [AW-1:0]       o_data
);
    localparam int PW = 2 * DW;
    localparam int TW = PW + $clog2(NLANE);

    logic signed [PW-1:0] w_prod;
    logic signed [TW-1:0] w_sum;
    logic        [AW-1:0] w_psum;
    logic        [AW-1:0] w_res;
    logic        [AW-1:0] r_psum;
    logic        [AW-1:0] r_acc;
    logic        [AW-1:0] r_out;

    // Lane 0 sits in the MSBs of both vectors.
    always_comb begin
        w_sum  = '0;
        w_prod = '0;
        for (int l = 0; l < NLANE; l++) begin
            w_prod = PW'($signed(i_data[(NLANE-1-l)*DW +: DW]))
                   * PW'($signed(i_weight[(NLANE-1-l)*DW +: DW]));
            w_sum  = w_sum + TW'(w_prod);
        end
    end

    assign w_psum = AW'(w_sum);

    always_comb begin
`ifdef PWCONV_ENGINE_RELU_EN
        w_res = r_acc[AW-1] ? '0 : r_acc;
`else
        w_res = r_acc;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_psum <= '0;
            r_acc  <= '0;
            r_out  <= '0;
        end else if (i_adv) begin
            r_psum <= w_psum;
            if (i_s1_valid) begin
                r_acc <= (i_s1_first ? i_s1_bias : r_acc) + r_psum;
            end
            if (i_s2_emit) begin
                r_out <= w_res;
            end
        end
    end

    assign o_data = r_out;
endmodule

// File: rtl/pwconv_engine.sv
// Pointwise-convolution engine: bias RAM, S1/S2 control pipeline and NPOINT point slices.
// Build option PWCONV_ENGINE_RELU_EN applies max(acc,0) to emitted results.
module pwconv_engine import pwconv_pkg::*; #(
    parameter int  NPOINT = PW_NPOINT,
    parameter int  NLANE  = PW_NLANE,
    parameter int  DW     = PW_DW,
    parameter int  AW     = PW_AW,
    parameter int  NOUT   = 32,
    localparam int CW     = $clog2(NOUT)
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic [CW-1:0]              in_cnt,
    input  logic [PW_TAG_W-1:0]        in_pos,
    input  logic [NLANE*DW-1:0]        in_weight,
    input  logic [NPOINT*NLANE*DW-1:0] in_data,
    input  logic                       bias_we,
    input  logic [CW-1:0]              bias_addr,
    input  logic [AW-1:0]              bias_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CW-1:0]              out_cnt,
    output logic [PW_TAG_W-1:0]        out_pos,
    output logic [NPOINT*AW-1:0]       out_data
);
    logic [AW-1:0]       r_bias [NOUT];
    logic                r_s1_valid;
    logic                r_s1_first;
    logic                r_s1_last;
    logic [CW-1:0]       r_s1_cnt;
    logic [PW_TAG_W-1:0] r_s1_pos;
    logic [AW-1:0]       r_s1_bias;
    logic                r_s2_valid;
    logic                r_s2_last;
    logic [CW-1:0]       r_s2_cnt;
    logic [PW_TAG_W-1:0] r_s2_pos;
    logic                r_out_valid;
    logic [CW-1:0]       r_out_cnt;
    logic [PW_TAG_W-1:0] r_out_pos;
    logic                w_adv;
    logic                w_emit;

    // The whole pipeline freezes only while a finished result waits on the consumer.
    assign w_adv     = !(r_out_valid && !out_ready);
    assign w_emit    = r_s2_valid && r_s2_last;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_cnt   = r_out_cnt;
    assign out_pos   = r_out_pos;

    // S1 samples r_bias before this edge's write lands, so a same-address read sees old data.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NOUT; i++) begin
                r_bias[i] <= '0;
            end
        end else if (bias_we) begin
            r_bias[bias_addr] <= bias_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_cnt    <= '0;
            r_s1_pos    <= '0;
            r_s1_bias   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_cnt    <= '0;
            r_s2_pos    <= '0;
            r_out_valid <= 1'b0;
            r_out_cnt   <= '0;
            r_out_pos   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
                r_s1_cnt   <= in_cnt;
                r_s1_pos   <= in_pos;
                r_s1_bias  <= r_bias[in_cnt];
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_last <= r_s1_last;
                r_s2_cnt  <= r_s1_cnt;
                r_s2_pos  <= r_s1_pos;
            end
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_cnt <= r_s2_cnt;
                r_out_pos <= r_s2_pos;
            end
        end
    end

    for (genvar p = 0; p < NPOINT; p++) begin : g_point
        pwconv_engine_point #(
            .NLANE (NLANE),
            .DW    (DW),
            .AW    (AW)
        ) u_point (
            .clk        (clk),
            .rst_b      (rst_b),
            .i_adv      (w_adv),
            .i_s1_valid (r_s1_valid),
            .i_s1_first (r_s1_first),
            .i_s2_emit  (w_emit),
            .i_s1_bias  (r_s1_bias),
            .i_weight   (in_weight),
            .i_data     (in_data[(NPOINT-1-p)*NLANE*DW +: NLANE*DW]),
            .o_data     (out_data[(NPOINT-1-p)*AW +: AW])
        );
    end
endmodule

// File: tb/tb_pwconv_engine.sv
// Bench for pwconv_engine: table vectors, directed pipeline corner cases and a random
// stream against an arithmetic model; all results go through an expected-result queue.
module tb_pwconv_engine;
    localparam int NPOINT = 4;
    localparam int NLANE  = 32;
    localparam int DW     = 8;
    localparam int AW     = 32;
    localparam int NOUT   = 32;
    localparam int CW     = 5;
    localparam int WW     = NLANE * DW;
    localparam int DWID   = NPOINT * WW;
    localparam int OW     = NPOINT * AW;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             in_valid, in_ready, in_first, in_last;
    logic [CW-1:0]    in_cnt;
    logic [3:0]       in_pos;
    logic [WW-1:0]    in_weight;
    logic [DWID-1:0]  in_data;
    logic             bias_we;
    logic [CW-1:0]    bias_addr;
    logic [AW-1:0]    bias_wdata;
    logic             out_valid, out_ready;
    logic [CW-1:0]    out_cnt;
    logic [3:0]       out_pos;
    logic [OW-1:0]    out_data;

    always #5 clk = ~clk;

    pwconv_engine #(
        .NPOINT (NPOINT),
        .NLANE  (NLANE),
        .DW     (DW),
        .AW     (AW),
        .NOUT   (NOUT)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_last    (in_last),
        .in_cnt     (in_cnt),
        .in_pos     (in_pos),
        .in_weight  (in_weight),
        .in_data    (in_data),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .bias_wdata (bias_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cnt    (out_cnt),
        .out_pos    (out_pos),
        .out_data   (out_data)
    );

    typedef struct {
        logic [CW-1:0] cnt;
        logic [3:0]    pos;
        logic [OW-1:0] data;
    } exp_t;

    typedef struct {
        int cnt;
        int pos;
        int dv;
        int wv;
        int bias;
        int expv;
    } vec_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    vec_t          vt[6];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            acc_m[NPOINT];
    int            bias_m[NOUT];
    bit            use_model = 1'b0;
    bit            rand_rdy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic [CW-1:0] prev_cnt;
    logic [3:0]    prev_pos;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int relu(input int v);
`ifdef PWCONV_ENGINE_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [OW-1:0] rep(input int v);
        logic [OW-1:0] r;
        for (int p = 0; p < NPOINT; p++) r[p*AW +: AW] = relu(v);
        return r;
    endfunction

    function automatic logic [WW-1:0] fill_w(input int v);
        logic [WW-1:0] r;
        for (int l = 0; l < NLANE; l++) r[l*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [DWID-1:0] fill_d(input int v);
        logic [DWID-1:0] r;
        for (int l = 0; l < NPOINT * NLANE; l++) r[l*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic int dot(input logic [WW-1:0] w, input logic [WW-1:0] d);
        int s = 0;
        logic signed [DW-1:0] a, b;
        for (int l = 0; l < NLANE; l++) begin
            a = d[WW-1-l*DW -: DW];
            b = w[WW-1-l*DW -: DW];
            s += int'(a) * int'(b);
        end
        return s;
    endfunction

    task automatic push_exp(input int c, input int p, input int v);
        exp_t e;
        e.cnt  = CW'(c);
        e.pos  = 4'(p);
        e.data = rep(v);
        exp_q.push_back(e);
    endtask

    task automatic wr_bias(input int a, input int v);
        bias_we    = 1'b1;
        bias_addr  = CW'(a);
        bias_wdata = AW'(v);
        @(posedge clk);
        #1 bias_we = 1'b0;
        bias_m[a] = v;
    endtask

    // Holds the beat until accepted; updates the model at the accepting edge.
    task automatic send(input logic f, input logic l, input int c, input int p,
                        input logic [WW-1:0] w, input logic [DWID-1:0] d);
        logic rdy;
        int   guard = 0;
        int   ps;
        exp_t e;
        in_valid = 1'b1; in_first = f; in_last = l;
        in_cnt = CW'(c); in_pos = 4'(p); in_weight = w; in_data = d;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            guard++;
        end while (!rdy && guard < 200);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_accept: got in_ready=0 for 200 cycles, expected acceptance");
        end else if (use_model) begin
            for (int pt = 0; pt < NPOINT; pt++) begin
                ps = dot(w, d[(NPOINT-1-pt)*WW +: WW]);
                acc_m[pt] = f ? bias_m[c] + ps : acc_m[pt] + ps;
            end
            if (l) begin
                e.cnt = CW'(c);
                e.pos = 4'(p);
                for (int pt = 0; pt < NPOINT; pt++) e.data[(NPOINT-1-pt)*AW +: AW] = relu(acc_m[pt]);
                exp_q.push_back(e);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results pending, expected 0", exp_q.size());
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: scoreboard pops on accepted results, stability check on stalled ones.
    initial forever begin
        @(negedge clk);
        if (!rst_b) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_tag", {out_cnt, out_pos}, {prev_cnt, prev_pos});
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got result cnt=%0d pos=%0d, expected none",
                             out_cnt, out_pos);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_cnt", out_cnt, mon_e.cnt);
                    chk("out_pos", out_pos, mon_e.pos);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_cnt   = out_cnt;
            prev_pos   = out_pos;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        logic [OW-1:0]   snap;
        logic [WW-1:0]   w1;
        logic [DWID-1:0] d1;
        logic            f, l;
        int              t0;

        vt[0] = '{8,  2, 3,    4,    0,    384};
        vt[1] = '{9,  3, -2,   5,    -5,   -325};
        vt[2] = '{10, 4, -128, -128, 1000, 525288};
        vt[3] = '{11, 5, 127,  -128, 100,  -520092};
        vt[4] = '{12, 6, 0,    77,   -1,   -1};
        vt[5] = '{13, 7, -1,   -1,   -5,   27};

        in_valid = 0; in_first = 0; in_last = 0; in_cnt = '0; in_pos = '0;
        in_weight = '0; in_data = '0; bias_we = 0; bias_addr = '0; bias_wdata = '0;
        out_ready = 1'b1;
        rst_b = 1'b1;
        #2 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_pos", out_pos, 0);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Single pass with latency check.
        wr_bias(3, 100);
        push_exp(3, 1, 164);
        send(1, 1, 3, 1, fill_w(2), fill_d(1));
        @(posedge clk);
        #1 chk("lat_edge1", out_valid, 0);
        @(posedge clk);
        #1 chk("lat_edge2", out_valid, 1);
        drain();

        // Table vectors, back to back.
        for (int i = 0; i < 6; i++) wr_bias(vt[i].cnt, vt[i].bias);
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            push_exp(vt[i].cnt, vt[i].pos, vt[i].expv);
            send(1, 1, vt[i].cnt, vt[i].pos, fill_w(vt[i].wv), fill_d(vt[i].dv));
        end
        chk("b2b_cycles", cyc - t0, 6);
        drain();

        // Two-pass accumulation onto bias[0]=0.
        push_exp(0, 9, 64);
        send(1, 0, 0, 8, fill_w(1), fill_d(-1));
        send(0, 1, 0, 9, fill_w(1), fill_d(3));
        drain();

        // Backpressure: three beats in flight, a fourth offered while stalled.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push_exp(3, 9 + k, 100 + 32 * k);
        for (int k = 1; k <= 3; k++) send(1, 1, 3, 9 + k, fill_w(1), fill_d(k));
        chk("bp_valid", out_valid, 1);
        snap = out_data;
        fork
            send(1, 1, 3, 13, fill_w(1), fill_d(4));
            begin
                repeat (5) begin
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold", out_data, snap);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Bias write colliding with a read of the same address.
        wr_bias(5, 2);
        push_exp(5, 1, 2);
        bias_we = 1'b1; bias_addr = CW'(5); bias_wdata = AW'(7);
        send(1, 1, 5, 1, fill_w(0), fill_d(0));
        bias_we = 1'b0;
        push_exp(5, 2, 7);
        send(1, 1, 5, 2, fill_w(0), fill_d(0));
        drain();

        // Accumulator wrap at the positive limit.
        wr_bias(6, 32'h7FFF_FFFF);
        push_exp(6, 3, int'(32'h8000_0000));
        w1 = fill_w(0);
        w1[WW-1 -: DW] = 8'd1;
        send(1, 1, 6, 3, w1, fill_d(1));
        drain();

        // Reset between passes abandons the partial sum and clears the bias RAM.
        send(1, 0, 3, 4, fill_w(1), fill_d(5));
        @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 chk("rst_no_valid", out_valid, 0);
        end
        chk("rst_mid_in_ready", in_ready, 1);
        rst_b = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 chk("post_rst_idle", out_valid, 0);
        end
        push_exp(3, 5, 192);
        send(1, 1, 3, 5, fill_w(3), fill_d(2));
        drain();

        // Random stream against the model; first beat after reset has first=0.
        rst_b = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        for (int i = 0; i < NOUT; i++) bias_m[i] = 0;
        for (int p = 0; p < NPOINT; p++) acc_m[p] = 0;
        for (int c = 0; c < 8; c++) wr_bias(c, int'($urandom_range(0, 2000)) - 1000);
        use_model = 1'b1;
        rand_rdy  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            f = (i == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
            l = (i == 29) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < NLANE; k++) w1[k*DW +: DW] = DW'($urandom);
            for (int k = 0; k < NPOINT * NLANE; k++) d1[k*DW +: DW] = DW'($urandom);
            send(f, l, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), w1, d1);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();
        use_model = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwconv_engine.md
PWCONV_ENGINE -- requirements
Module: pwconv_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NPOINT, 4, spatial points processed per beat.
- NLANE, 32, input channels per beat (dot-product length).
- DW, 8, signed data/weight width.
- AW, 32, signed accumulator/output width.
- NOUT, 32, output channels (bias depth); CW = clog2(NOUT).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_b, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block accepts beat.
- in_first, in, 1, first pass of an accumulation.
- in_last, in, 1, last pass; result emitted.
- in_cnt, in, CW, output-channel index (bias select).
- in_pos, in, 4, position tag, passed through.
- in_weight, in, NLANE*DW, weight vector, lane 0 in MSBs.
- in_data, in, NPOINT*NLANE*DW, point p at slice p, point 0 in MSBs.
- bias_we, in, 1, bias write strobe.
- bias_addr, in, CW, bias write address.
- bias_wdata, in, AW, signed bias value.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- out_cnt, out, CW, channel of result.
- out_pos, out, 4, position of result.
- out_data, out, NPOINT*AW, signed results, point 0 in MSBs.

Function
REQ-003 A beat SHALL transfer when in_valid and in_ready are both 1 on a rising clk edge; a result transfers when out_valid and out_ready are both 1.
REQ-004 Pipeline: S1 registers per-point dot product sum(data*weight) (full-precision products 2*DW, tree width 2*DW+clog2(NLANE), sign-extended to AW) plus bias[in_cnt], cnt, pos, first, last; S2 holds per-point accumulators.
REQ-005 In S2: first=1 SHALL load acc = bias + psum; first=0 SHALL load acc = acc + psum; all additions AW-bit two's-complement wrap.
REQ-006 out_valid SHALL assert in the cycle after S2 update only when last=1; a first&last beat accepted at edge N gives out_valid after edge N+2 (latency 2).
REQ-007 in_ready SHALL equal !(out_valid && !out_ready); when stalled S1 and S2 SHALL hold; out_data/out_cnt/out_pos SHALL stay stable while out_valid && !out_ready.
REQ-008 out_valid SHALL deassert after the accepting edge unless a new last-result completes on that same edge; back-to-back single-pass beats SHALL sustain 1 result per cycle with out_ready=1.
REQ-009 first=1 arriving mid-accumulation SHALL discard the partial sum and restart; first=0 as the first beat after reset SHALL accumulate onto acc=0 (bias not added).
REQ-010 Bias RAM: NOUT x AW, written on bias_we at the edge; a write and an S1 read of the same address on one edge SHALL return the old value.
REQ-011 in_cnt and in_pos SHALL be those of the last beat of the accumulation when emitted.

Reset
REQ-012 On rst_b=0: S1/S2 valids, accumulators, out_valid, out_cnt, out_pos, out_data SHALL clear to 0; in_ready SHALL be 1; bias RAM contents SHALL clear to 0.
REQ-013 Reset mid-accumulation SHALL abandon the partial sum; no result is emitted.

Configuration
REQ-014 With PWCONV_ENGINE_RELU_EN defined, each emitted out_data point SHALL be max(acc,0); without it the raw signed acc SHALL be emitted; accumulation itself is unaffected.

Structure
REQ-015 Package pwconv_pkg SHALL hold default DW/AW/NLANE/NPOINT constants and the tag width (4).
REQ-016 One sub-module pwconv_engine_point SHALL implement a single point's dot product, S1 register and S2 accumulator, instantiated NPOINT times via generate.

Verification
REQ-017 Single pass: bias[3]=100, all data=1, all weights=2, first=last=1, cnt=3 -> out_data each point 164, out_cnt=3 after 2 cycles.
REQ-018 Two passes: bias[0]=0, pass1 data=-1 weight=1, pass2 data=3 weight=1 -> one result, each point 64.
REQ-019 Backpressure: out_ready=0 for 5 cycles with 3 beats offered -> in_ready low, out_data stable, no beat lost, 3 results in order.
REQ-020 Bias collision: write bias[5]=7 same edge as beat cnt=5 (old 2), all-zero data -> result 2; next beat -> 7.
REQ-021 Wrap/ReLU: bias=0x7FFFFFFF plus psum 1 -> 0x80000000 without macro, 0 with PWCONV_ENGINE_RELU_EN.
REQ-022 Reset asserted between pass 1 and pass 2 -> no out_valid; subsequent first=last beat gives correct fresh result.
